// File: rtl/sram_controller.sv
// Controller for the external 32-bit SRAM of the pipeline memory stage. It stalls the pipeline via ready while an access runs.
// Optional build macro SRAM_CTRL_RANGE_CHK_EN adds the addr_err output and rejects requests outside the mapped window.
module sram_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [16:0] SRAM_addr,
    output logic        SRAM_we_n,
    inout  wire  [31:0] SRAM_dq
`ifdef SRAM_CTRL_RANGE_CHK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              op_write_reg, op_write_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [16:0]       sram_addr_reg, sram_addr_next;
    logic              we_n_reg, we_n_next;
    logic [31:0]       read_data_reg, read_data_next;
    logic [31:0]       addr_diff;
    logic              range_err;
    logic              req;

    assign req       = rd_en | wr_en;
    assign addr_diff = address - 32'(BASE_ADDR);

`ifdef SRAM_CTRL_RANGE_CHK_EN
    logic addr_err_reg, addr_err_next;
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_diff[1:0];
    assign range_err        = (address < 32'(BASE_ADDR)) || (addr_diff[31:2] >= 30'(DEPTH));
    // Error flag lives exactly for the DONE cycle that follows a rejected request.
    assign addr_err_next    = (state_reg == IDLE) && req && range_err;
    assign addr_err         = addr_err_reg;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_diff[31:19], addr_diff[1:0]};
    assign range_err        = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_write_next  = op_write_reg;
        wdata_next     = wdata_reg;
        sram_addr_next = sram_addr_reg;
        we_n_next      = we_n_reg;
        read_data_next = read_data_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    op_write_next = wr_en;
                    cnt_next      = '0;
                    if (range_err) begin
                        // Rejected request: no SRAM cycle, a read returns zero.
                        state_next = DONE;
                        if (!wr_en) begin
                            read_data_next = '0;
                        end
                    end else begin
                        state_next     = ACCESS;
                        sram_addr_next = addr_diff[18:2];
                        wdata_next     = write_data;
                        we_n_next      = ~wr_en;
                    end
                end
            end
            ACCESS: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                    we_n_next  = 1'b1;
                    if (!op_write_reg) begin
                        read_data_next = SRAM_dq;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_write_reg  <= 1'b0;
            wdata_reg     <= '0;
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
            read_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_write_reg  <= op_write_next;
            wdata_reg     <= wdata_next;
            sram_addr_reg <= sram_addr_next;
            we_n_reg      <= we_n_next;
            read_data_reg <= read_data_next;
        end
    end

`ifdef SRAM_CTRL_RANGE_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= addr_err_next;
        end
    end
`endif

    assign ready     = ((state_reg == IDLE) && !req) || (state_reg == DONE);
    assign read_data = read_data_reg;
    assign SRAM_addr = sram_addr_reg;
    assign SRAM_we_n = we_n_reg;
    assign SRAM_dq   = ((state_reg == ACCESS) && op_write_reg) ? wdata_reg : 32'bz;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the external 32-bit SRAM for the memory stage of the ARM pipeline.
- Accepts one read or write request from the MEM stage at a time.
- Translates the byte address into a 17-bit SRAM word address and drives SRAM_we_n and the bidirectional SRAM_dq bus.
- Holds ready low (pipeline freeze) until the access completes, so the 30 ns SRAM read delay is covered by a programmable number of wait cycles.

Parameters:
- WAIT_CYCLES, 5, cycles spent in ACCESS per request; must be >=1 and WAIT_CYCLES*Tclk > 30 ns.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- DEPTH, 512, number of SRAM words; used only by the optional range check.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous reset, active-high.
- rd_en  input  1  read request from MEM stage; held until ready.
- wr_en  input  1  write request from MEM stage; held until ready.
- address  input  32  byte address, word aligned.
- write_data  input  32  store data.
- read_data  output  32  load data, registered.
- ready  output  1  low = freeze pipeline.
- SRAM_addr  output  17  SRAM word address, registered.
- SRAM_we_n  output  1  SRAM write enable, active-low, registered.
- SRAM_dq  inout  32  SRAM data bus.

Behaviour:
- Reset state (async, immediate on rst high, also mid-access): state=IDLE, cnt=0, read_data=0, SRAM_addr=0, SRAM_we_n=1, SRAM_dq=Z. Any in-flight access is abandoned; no partial write is guaranteed beyond edges already taken.
- Address translation: SRAM_addr <= ((address - BASE_ADDR) >> 2)[16:0]. 32-bit subtraction; low 2 bits ignored.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If wr_en or rd_en: latch op, SRAM_addr and write data; cnt<=0; go to ACCESS.
  - If both rd_en and wr_en are high, the write wins.
  - For a write, SRAM_we_n<=0 on the same edge.
- ACCESS:
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1: go to DONE and set SRAM_we_n<=1.
  - For a read, read_data<=SRAM_dq on that edge.
- DONE: one cycle only; go to IDLE unconditionally.
- ready (combinational) = (state==IDLE && !rd_en && !wr_en) || state==DONE.
- Latency: request seen in IDLE at cycle 0, ACCESS for cycles 1..WAIT_CYCLES, ready=1 in cycle WAIT_CYCLES+1. Total WAIT_CYCLES+2 cycles per access.
- Back-to-back requests: the request present in the cycle after DONE starts a new access. No bubble other than that IDLE cycle.
- SRAM_dq is driven with the latched write data only while state==ACCESS and op==write; otherwise Z.
- Write semantics: SRAM_we_n is low for exactly WAIT_CYCLES cycles. Repeated SRAM writes to the same word with the same data are harmless.
- read_data holds its last value until the next read completes. Writes never change it.
- Requests dropped while in ACCESS are ignored; the latched access completes.

Optional Feature:
Macro SRAM_CTRL_RANGE_CHK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - In IDLE, a request is out of range if address < BASE_ADDR or the word index >= DEPTH.
  - An out-of-range request skips ACCESS and goes directly to DONE: SRAM_we_n stays 1, read_data<=0 for reads, addr_err=1 during that DONE cycle only.
- Undefined: no addr_err port; the address is truncated to 17 bits with no check.

Test Plan:
- Reset mid-write: assert rst during ACCESS cycle 3 -> SRAM_we_n=1, SRAM_dq=Z, ready=1 (no request), read_data=0 immediately.
- Single write: wr_en=1, address=1024+8, write_data=0xDEADBEEF.
  - Response: SRAM_addr=2, SRAM_we_n=0 for exactly 5 cycles, ready low 6 cycles then high 1 cycle.
  - Memory word 2 = 0xDEADBEEF.
- Read after write (Tclk=20 ns): rd_en=1, address=1032 -> ready high in cycle 6, read_data=0xDEADBEEF, SRAM_we_n stays 1, SRAM_dq never driven by the controller.
- Simultaneous rd_en and wr_en: address=1028, write_data=0x12345678 -> write performed at word 1, read_data unchanged.
- Back-to-back: write 0xA5A5A5A5 to 1036, then immediately read 1036 -> second access starts the cycle after the first DONE, read_data=0xA5A5A5A5, total 14 cycles.
- SRAM_CTRL_RANGE_CHK_EN: rd_en with address=1020 -> ready in cycle 1, addr_err=1 for one cycle, read_data=0, no SRAM activity. Address=1024+4*512 gives the same response.
